// File: rtl/debug_cnt_pkg.sv
// debug_cnt_pkg
//   Shared constants and width helpers for the multi-channel debug counter.
//   DEF_*      : default parameter values for debug_cnt_mc
//   clog2()    : ceiling log2, safe for values up to 2^32
//   sel_width(): readout select width, never narrower than one bit
package debug_cnt_pkg;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_CNT_WIDTH   = 25;
    localparam int DEF_STRETCH_CYC = 1000000;

    // 64-bit shift keeps the comparison positive for large arguments
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (longint'(v) > (longint'(1) << i)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/debug_cnt_mc_if.sv
// debug_cnt_mc_if
//   Counter readout handshake.
//   rd_sel  : channel to capture (master -> slave)
//   rd_req  : capture request, one per cycle (master -> slave)
//   rd_ack  : one-cycle strobe, rd_data valid (slave -> master)
//   rd_data : captured counter value, held between acks (slave -> master)
interface debug_cnt_mc_if
    import debug_cnt_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
    localparam int SEL_W = sel_width(NUM_CH);

    logic [SEL_W-1:0]     rd_sel;
    logic                 rd_req;
    logic                 rd_ack;
    logic [CNT_WIDTH-1:0] rd_data;

    modport master (output rd_sel, output rd_req, input  rd_ack, input  rd_data);
    modport slave  (input  rd_sel, input  rd_req, output rd_ack, output rd_data);

endinterface

// File: rtl/debug_cnt_ch.sv
// debug_cnt_ch
//   One counter channel: edge/level increment qualifier, wrap/saturate
//   counter, sticky event and overflow flags, retriggerable LED stretcher.
//   clk, rst      : clock, synchronous active-high reset
//   cnt_en_i      : event / enable input
//   mode_edge_i   : 1 = count rising edges, 0 = count enabled cycles
//   sat_en_i      : 1 = saturate at all-ones, 0 = wrap
//   clr_i         : clear counter and sticky flags (not the stretcher)
//   cnt_o         : counter register
//   led_evt_o     : sticky event seen
//   led_act_o     : stretched activity
//   ovf_o         : sticky overflow / saturation
module debug_cnt_ch
    import debug_cnt_pkg::*;
#(
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int STRETCH_CYC = DEF_STRETCH_CYC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cnt_en_i,
    input  logic                 mode_edge_i,
    input  logic                 sat_en_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 led_evt_o,
    output logic                 led_act_o,
    output logic                 ovf_o
);
    localparam int TMR_W = clog2(STRETCH_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STRETCH_CYC);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic                 evt_q, evt_d;
    logic                 ovf_q, ovf_d;
    logic                 prev_q;
    logic                 inc;

    always_comb begin
        inc   = cnt_en_i & (~mode_edge_i | ~prev_q);
        cnt_d = cnt_q;
        evt_d = evt_q;
        ovf_d = ovf_q;
        tmr_d = tmr_q;

        // stretcher follows increments only; clear deliberately leaves it alone
        if (inc)                tmr_d = TMR_LOAD;
        else if (tmr_q != '0)   tmr_d = tmr_q - TMR_W'(1);

        if (clr_i) begin
            cnt_d = '0;
            evt_d = 1'b0;
            ovf_d = 1'b0;
        end else if (inc) begin
            evt_d = 1'b1;
            if (&cnt_q) begin
                ovf_d = 1'b1;
                cnt_d = sat_en_i ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tmr_q  <= '0;
            evt_q  <= 1'b0;
            ovf_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tmr_q  <= tmr_d;
            evt_q  <= evt_d;
            ovf_q  <= ovf_d;
            prev_q <= cnt_en_i;
        end
    end

    assign cnt_o     = cnt_q;
    assign led_evt_o = evt_q;
    assign led_act_o = (tmr_q != '0);
    assign ovf_o     = ovf_q;

endmodule

// File: rtl/debug_cnt_mc.sv
// debug_cnt_mc
//   NUM_CH independent debug event counters with LED indicators and a
//   single-cycle-latency readout port.
//   clk, rst   : clock, synchronous active-high reset
//   cnt_en     : per-channel event / enable
//   mode_edge  : 1 = count rising edges, 0 = count enabled cycles
//   sat_en     : 1 = saturate, 0 = wrap
//   clr        : per-channel clear
//   rd         : readout handshake (rd_sel/rd_req in, rd_ack/rd_data out)
//   led_cnt    : counter MSB per channel
//   led_evt    : sticky event seen per channel
//   led_act    : stretched activity per channel
//   ovf        : sticky overflow per channel
module debug_cnt_mc
    import debug_cnt_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int STRETCH_CYC = DEF_STRETCH_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] cnt_en,
    input  logic              mode_edge,
    input  logic              sat_en,
    input  logic [NUM_CH-1:0] clr,
    debug_cnt_mc_if.slave     rd,
    output logic [NUM_CH-1:0] led_cnt,
    output logic [NUM_CH-1:0] led_evt,
    output logic [NUM_CH-1:0] led_act,
    output logic [NUM_CH-1:0] ovf
);
    localparam int SEL_W     = sel_width(NUM_CH);
    localparam int RD_STAGES = 1;

    logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt_all;
    logic [CNT_WIDTH-1:0]             rd_mux;
    logic [CNT_WIDTH-1:0]             rd_data_q;
    logic [RD_STAGES:0]               vld_pipe;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debug_cnt_ch #(
            .CNT_WIDTH   (CNT_WIDTH),
            .STRETCH_CYC (STRETCH_CYC)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .cnt_en_i    (cnt_en[i]),
            .mode_edge_i (mode_edge),
            .sat_en_i    (sat_en),
            .clr_i       (clr[i]),
            .cnt_o       (cnt_all[i]),
            .led_evt_o   (led_evt[i]),
            .led_act_o   (led_act[i]),
            .ovf_o       (ovf[i])
        );
        assign led_cnt[i] = cnt_all[i][CNT_WIDTH-1];
    end

    // an unmatched select (>= NUM_CH) falls through to zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd.rd_sel == SEL_W'(i)) rd_mux = cnt_all[i];
        end
    end

    assign vld_pipe[0] = rd.rd_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[RD_STAGES:1] <= '0;
            rd_data_q             <= '0;
        end else begin
            vld_pipe[RD_STAGES:1] <= vld_pipe[RD_STAGES-1:0];
            if (rd.rd_req) rd_data_q <= rd_mux;
        end
    end

    assign rd.rd_ack  = vld_pipe[RD_STAGES];
    assign rd.rd_data = rd_data_q;

endmodule

// File: tb/tb_debug_cnt_mc.sv
module tb_debug_cnt_mc;
    localparam int NCH = 2;
    localparam int CW  = 4;
    localparam int STR = 3;
    localparam int MAXV = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NCH-1:0] cnt_en = '0, clr = '0;
    logic mode_edge = 1'b0, sat_en = 1'b0;
    logic [NCH-1:0] led_cnt, led_evt, led_act, ovf;

    debug_cnt_mc_if #(.NUM_CH(NCH), .CNT_WIDTH(CW)) rd_if ();

    debug_cnt_mc #(.NUM_CH(NCH), .CNT_WIDTH(CW), .STRETCH_CYC(STR)) dut (
        .clk(clk), .rst(rst), .cnt_en(cnt_en), .mode_edge(mode_edge),
        .sat_en(sat_en), .clr(clr), .rd(rd_if.slave), .led_cnt(led_cnt),
        .led_evt(led_evt), .led_act(led_act), .ovf(ovf)
    );

    // three-channel instance: two-bit select exposes an out-of-range code
    logic [2:0] en3 = '0;
    logic [2:0] lc3, le3, la3, ov3;
    debug_cnt_mc_if #(.NUM_CH(3), .CNT_WIDTH(CW)) rd3 ();

    debug_cnt_mc #(.NUM_CH(3), .CNT_WIDTH(CW), .STRETCH_CYC(STR)) dut3 (
        .clk(clk), .rst(rst), .cnt_en(en3), .mode_edge(1'b0),
        .sat_en(1'b0), .clr(3'b000), .rd(rd3.slave), .led_cnt(lc3),
        .led_evt(le3), .led_act(la3), .ovf(ov3)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model: counts as integers, activity as "cycles since last increment"
    int mcnt[NCH];
    bit mprev[NCH], mevt[NCH], movf[NCH], mlast_v[NCH];
    int mlast[NCH];
    bit mack;
    int mdata;
    int cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @step %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic model_update(input logic [NCH-1:0] en, input logic [NCH-1:0] cl,
                                input int sel, input bit rq, input bit r);
        cyc++;
        if (r) begin
            for (int c = 0; c < NCH; c++) begin
                mcnt[c] = 0; mprev[c] = 0; mevt[c] = 0; movf[c] = 0; mlast_v[c] = 0;
            end
            mack = 0; mdata = 0;
            return;
        end
        mack = rq;
        if (rq) mdata = (sel < NCH) ? mcnt[sel] : 0;
        for (int c = 0; c < NCH; c++) begin
            bit inc;
            inc = en[c] && (!mode_edge || !mprev[c]);
            mprev[c] = en[c];
            if (inc) begin mlast[c] = cyc; mlast_v[c] = 1; end
            if (cl[c]) begin
                mcnt[c] = 0; mevt[c] = 0; movf[c] = 0;
            end else if (inc) begin
                mevt[c] = 1;
                if (mcnt[c] + 1 > MAXV) movf[c] = 1;
                mcnt[c] = sat_en ? ((mcnt[c] + 1 > MAXV) ? MAXV : mcnt[c] + 1)
                                 : (mcnt[c] + 1) % (MAXV + 1);
            end
        end
    endtask

    task automatic step(input logic [NCH-1:0] en, input logic [NCH-1:0] cl,
                        input int sel, input bit rq, input bit r);
        logic [NCH-1:0] e_cnt, e_evt, e_act, e_ovf;
        cnt_en = en; clr = cl; rd_if.rd_sel = sel[0]; rd_if.rd_req = rq; rst = r;
        model_update(en, cl, sel, rq, r);
        @(posedge clk); #1;
        for (int c = 0; c < NCH; c++) begin
            e_cnt[c] = (mcnt[c] >= (1 << (CW - 1)));
            e_evt[c] = mevt[c];
            e_ovf[c] = movf[c];
            e_act[c] = mlast_v[c] && ((cyc - mlast[c]) < STR);
        end
        chk("led_cnt", int'(led_cnt), int'(e_cnt));
        chk("led_evt", int'(led_evt), int'(e_evt));
        chk("led_act", int'(led_act), int'(e_act));
        chk("ovf",     int'(ovf),     int'(e_ovf));
        chk("rd_ack",  int'(rd_if.rd_ack), int'(mack));
        chk("rd_data", int'(rd_if.rd_data), mdata);
    endtask

    task automatic do_rst();
        step('0, '0, 0, 0, 1);
        step('0, '0, 0, 0, 1);
    endtask

    task automatic rd_expect(input int sel, input int exp, input string nm);
        step('0, '0, sel, 1, 0);
        chk({nm, "_ack"}, int'(rd_if.rd_ack), 1);
        chk(nm, int'(rd_if.rd_data), exp);
    endtask

    typedef struct {
        logic [NCH-1:0] en;
        logic [NCH-1:0] cl;
        int             sel;
        bit             rq;
        bit             x_ack;
        int             x_data;
        logic [NCH-1:0] x_evt;
    } vec_t;

    vec_t tbl[9];

    initial begin
        rd_if.rd_sel = '0; rd_if.rd_req = 1'b0;
        rd3.rd_sel = '0; rd3.rd_req = 1'b0;
        tbl[0] = '{2'b01, 2'b00, 0, 0, 0, 0, 2'b01};
        tbl[1] = '{2'b11, 2'b00, 0, 1, 1, 1, 2'b11};
        tbl[2] = '{2'b00, 2'b00, 1, 1, 1, 1, 2'b11};
        tbl[3] = '{2'b00, 2'b00, 0, 0, 0, 1, 2'b11};
        tbl[4] = '{2'b00, 2'b01, 0, 1, 1, 2, 2'b10};
        tbl[5] = '{2'b10, 2'b00, 0, 1, 1, 0, 2'b10};
        tbl[6] = '{2'b00, 2'b00, 1, 1, 1, 2, 2'b10};
        tbl[7] = '{2'b01, 2'b01, 0, 0, 0, 2, 2'b10};
        tbl[8] = '{2'b00, 2'b00, 0, 1, 1, 0, 2'b10};

        // reset state
        do_rst();
        chk("rst_outs", int'({led_cnt, led_evt, led_act, ovf}), 0);
        chk("rst_rd", int'({rd_if.rd_ack, rd_if.rd_data}), 0);

        // table: level mode with reads, clears and clear-over-increment
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].en, tbl[i].cl, tbl[i].sel, tbl[i].rq, 0);
            chk($sformatf("tbl%0d_ack", i), int'(rd_if.rd_ack), int'(tbl[i].x_ack));
            chk($sformatf("tbl%0d_data", i), int'(rd_if.rd_data), tbl[i].x_data);
            chk($sformatf("tbl%0d_evt", i), int'(led_evt), int'(tbl[i].x_evt));
        end

        // level mode, five cycles on ch0
        do_rst();
        repeat (5) step(2'b01, '0, 0, 0, 0);
        chk("lvl_evt", int'(led_evt), 1);
        chk("lvl_ovf", int'(ovf), 0);
        rd_expect(0, 5, "lvl_cnt0");
        rd_expect(1, 0, "lvl_cnt1");

        // wrap: MSB rises on the 8th, falls on the 16th, ovf on the 16th
        do_rst();
        for (int k = 1; k <= 16; k++) begin
            step(2'b01, '0, 0, 0, 0);
            if (k == 7)  chk("wrap_msb7", int'(led_cnt[0]), 0);
            if (k == 8)  chk("wrap_msb8", int'(led_cnt[0]), 1);
            if (k == 15) chk("wrap_ovf15", int'(ovf[0]), 0);
        end
        chk("wrap_msb16", int'(led_cnt[0]), 0);
        chk("wrap_ovf16", int'(ovf[0]), 1);
        rd_expect(0, 0, "wrap_cnt");

        // saturate
        do_rst();
        sat_en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(2'b01, '0, 0, 0, 0);
            if (k == 15) chk("sat_ovf15", int'(ovf[0]), 0);
            if (k == 16) chk("sat_ovf16", int'(ovf[0]), 1);
        end
        rd_expect(0, 15, "sat_cnt");
        sat_en = 1'b0;

        // edge mode: high 4, low 2, high 1
        do_rst();
        mode_edge = 1'b1;
        repeat (4) step(2'b10, '0, 0, 0, 0);
        repeat (2) step(2'b00, '0, 0, 0, 0);
        step(2'b10, '0, 0, 0, 0);
        step(2'b00, '0, 0, 0, 0);
        rd_expect(1, 2, "edge_cnt1");

        // enable already high across reset release counts as an edge
        step(2'b11, '0, 0, 0, 1);
        chk("rel_outs", int'({led_cnt, led_evt, led_act, ovf, rd_if.rd_ack, rd_if.rd_data}), 0);
        step(2'b11, '0, 0, 0, 0);
        step(2'b11, '0, 0, 0, 0);
        chk("rel_evt", int'(led_evt), 3);
        rd_expect(0, 1, "rel_cnt0");
        mode_edge = 1'b0;

        // clear wins over increment at count 7; stretcher unaffected
        do_rst();
        repeat (7) step(2'b01, '0, 0, 0, 0);
        step(2'b01, 2'b01, 0, 0, 0);
        chk("clr_evt", int'(led_evt[0]), 0);
        chk("clr_ovf", int'(ovf[0]), 0);
        chk("clr_act", int'(led_act[0]), 1);
        rd_expect(0, 0, "clr_cnt");

        // read captures pre-increment value
        do_rst();
        repeat (5) step(2'b10, '0, 0, 0, 0);
        step(2'b10, '0, 1, 1, 0);
        chk("pre_ack", int'(rd_if.rd_ack), 1);
        chk("pre_data", int'(rd_if.rd_data), 5);
        rd_expect(1, 6, "post_cnt1");
        step('0, '0, 0, 0, 0);
        chk("ack_strobe", int'(rd_if.rd_ack), 0);
        chk("data_hold", int'(rd_if.rd_data), 6);

        // out-of-range select on the three-channel instance
        en3 = 3'b001;
        repeat (3) step('0, '0, 0, 0, 0);
        en3 = 3'b000;
        rd3.rd_sel = 2'd0; rd3.rd_req = 1'b1;
        step('0, '0, 0, 0, 0);
        chk("oor_pre", int'(rd3.rd_data), 3);
        rd3.rd_sel = 2'd3;
        step('0, '0, 0, 0, 0);
        chk("oor_ack", int'(rd3.rd_ack), 1);
        chk("oor_data", int'(rd3.rd_data), 0);
        rd3.rd_req = 1'b0;

        // stretcher: single event, then retrigger
        do_rst();
        step(2'b01, '0, 0, 0, 0);
        chk("act_1", int'(led_act[0]), 1);
        step('0, '0, 0, 0, 0); chk("act_2", int'(led_act[0]), 1);
        step('0, '0, 0, 0, 0); chk("act_3", int'(led_act[0]), 1);
        step('0, '0, 0, 0, 0); chk("act_4", int'(led_act[0]), 0);
        step(2'b01, '0, 0, 0, 0);
        step('0, '0, 0, 0, 0);
        step(2'b01, '0, 0, 0, 0);
        step('0, '0, 0, 0, 0); chk("retrig_2", int'(led_act[0]), 1);
        step('0, '0, 0, 0, 0); chk("retrig_3", int'(led_act[0]), 1);
        step('0, '0, 0, 0, 0); chk("retrig_4", int'(led_act[0]), 0);

        // reset mid-count
        repeat (9) step(2'b11, '0, 0, 0, 0);
        step(2'b11, 2'b01, 1, 1, 1);
        chk("midrst", int'({led_cnt, led_evt, led_act, ovf, rd_if.rd_ack, rd_if.rd_data}), 0);

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            logic [NCH-1:0] en, cl;
            if ($urandom_range(0, 31) == 0) mode_edge = ~mode_edge;
            if ($urandom_range(0, 31) == 0) sat_en = ~sat_en;
            en = NCH'($urandom);
            cl = ($urandom_range(0, 15) == 0) ? NCH'($urandom) : '0;
            step(en, cl, int'($urandom_range(0, NCH - 1)), bit'($urandom_range(0, 1)),
                 $urandom_range(0, 149) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
